// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// Optional forwarding is enabled by defining HAZARD_FWD_EN.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned DEPTH_DEF  = 3;
    // Entry rd field is sized for the widest supported register index.
    localparam int unsigned REG_AW_MAX = 8;
    localparam int unsigned FWD_W      = 3;

    localparam logic [FWD_W-1:0] FWD_RF = '0;

    typedef struct packed {
        logic                  v;
        logic [REG_AW_MAX-1:0] rd;
        logic                  ld;
    } sb_entry_t;

endpackage

// File: rtl/hazard_operand_match.sv
// Priority match of one source operand against the scoreboard entries.
// HAZARD_FWD_EN selects load-aware forwarding; otherwise wait for WB.
module hazard_operand_match
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned LOAD_READY = 1
) (
    input  sb_entry_t [DEPTH-1:0]  entries,
    input  logic [REG_AW_MAX-1:0]  operand,
    input  logic                   used,
    output logic                   hit_not_ready,
    output logic [FWD_W-1:0]       sel
);

    logic [DEPTH-1:0] match;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            match[i] = used && (operand != '0) && entries[i].v && (entries[i].rd == operand);
        end
    end

`ifdef HAZARD_FWD_EN
    always_comb begin
        hit_not_ready = 1'b0;
        sel           = FWD_RF;
        // Walk oldest to youngest so the youngest match wins the select.
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel = FWD_W'(i + 1);
                if (entries[i].ld && (i < int'(LOAD_READY))) begin
                    hit_not_ready = 1'b1;
                end
            end
        end
    end
`else
    localparam int unsigned unused_load_ready = LOAD_READY;
    logic [DEPTH-1:0] unused_ld;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            unused_ld[i] = entries[i].ld;
        end
    end

    // Without bypass the consumer waits until the producer sits in the last entry.
    always_comb begin
        hit_not_ready = |match[DEPTH-2:0];
        sel           = FWD_RF;
    end
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: in-flight rd tracking, stall, forward selects, stall counter.
// Define HAZARD_FWD_EN to enable bypass selects and load-aware stalling.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic              issue,
    output logic [2:0]        fwd_rs_sel,
    output logic [2:0]        fwd_rt_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  rs_hit, rt_hit;

    hazard_operand_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY)
    ) u_match_rs (
        .entries       (entries_q),
        .operand       (REG_AW_MAX'(id_rs)),
        .used          (id_rs_used),
        .hit_not_ready (rs_hit),
        .sel           (fwd_rs_sel)
    );

    hazard_operand_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY)
    ) u_match_rt (
        .entries       (entries_q),
        .operand       (REG_AW_MAX'(id_rt)),
        .used          (id_rt_used),
        .hit_not_ready (rt_hit),
        .sel           (fwd_rt_sel)
    );

    assign stall     = id_valid & ~flush & (rs_hit | rt_hit);
    assign issue     = id_valid & ~stall & ~flush;
    assign stall_cnt = cnt_q;

    always_comb begin
        entries_d[0].v  = issue & id_wr_en & (id_rd != '0);
        entries_d[0].rd = REG_AW_MAX'(id_rd);
        entries_d[0].ld = id_is_load;
        for (int i = 1; i < int'(DEPTH); i++) begin
            entries_d[i] = entries_q[i-1];
        end
        // Squash the ID and EX instructions; older stages drain normally.
        if (flush) begin
            entries_d[0].v = 1'b0;
            entries_d[1].v = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            cnt_q     <= '0;
        end else begin
            entries_q <= entries_d;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
